// File: rtl/icache_l1_assoc_if.sv
// Processor-side and L2-side bus of the read-only L1 instruction cache.
// The cache takes the slave view; the fetch unit and L2 together take the master view.
interface icache_l1_assoc_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4
);
    localparam int LINE_W = ADDR_W - $clog2(WORDS);

    logic                      proc_read;
    logic [ADDR_W-1:0]         proc_addr;
    logic                      proc_flush;
    logic [DATA_W-1:0]         proc_rdata;
    logic                      proc_stall;
    logic                      L2_read;
    logic [LINE_W-1:0]         L2_addr;
    logic [DATA_W*WORDS-1:0]   L2_rdata;
    logic                      L2_ready;

    modport master (
        output proc_read, proc_addr, proc_flush, L2_rdata, L2_ready,
        input  proc_rdata, proc_stall, L2_read, L2_addr
    );

    modport slave (
        input  proc_read, proc_addr, proc_flush, L2_rdata, L2_ready,
        output proc_rdata, proc_stall, L2_read, L2_addr
    );
endinterface

// File: rtl/icache_l1_assoc.sv
// Read-only L1 cache, 1- or 2-way set associative with LRU replacement.
// Hits answer combinationally; misses fetch a whole line from L2 and then replay as a hit.
module icache_l1_assoc #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int SETS   = 8,
    parameter int WAYS   = 2,
    parameter int WORDS  = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             proc_reset,
    icache_l1_assoc_if.slave bus,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = ADDR_W - OFF_W;

    typedef enum logic {IDLE, FETCH} state_t;
    state_t state, next_state;

    logic [WAYS-1:0]         valid    [SETS];
    logic [TAG_W-1:0]        tag_mem  [SETS][WAYS];
    logic [DATA_W*WORDS-1:0] data_mem [SETS][WAYS];

    logic [LINE_W-1:0] miss_line;
    logic              miss_way;

    logic [TAG_W-1:0]        req_tag, fill_tag;
    logic [IDX_W-1:0]        req_idx, fill_idx;
    logic [OFF_W-1:0]        req_off;
    logic [WAYS-1:0]         way_hit;
    logic                    hit, hit_way, victim_way;
    logic [DATA_W*WORDS-1:0] hit_line;
    logic                    do_hit, do_miss, do_fill, do_flush;

    assign {req_tag, req_idx, req_off} = bus.proc_addr;
    assign {fill_tag, fill_idx}        = miss_line;
    assign bus.L2_read = (state == FETCH);
    assign bus.L2_addr = miss_line;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_hit[w] = valid[req_idx][w] && (tag_mem[req_idx][w] == req_tag);
    end

    assign hit      = |way_hit;
    assign hit_line = data_mem[req_idx][hit_way];

    // The LRU bit names the way to replace next; only a 2-way cache keeps one.
    if (WAYS == 2) begin : g_two
        logic [SETS-1:0] lru;

        assign hit_way = way_hit[1];

        always_comb begin
            if (!valid[req_idx][0])
                victim_way = 1'b0;
            else if (!valid[req_idx][1])
                victim_way = 1'b1;
            else
                victim_way = lru[req_idx];
        end

        always_ff @(posedge clk) begin
            if (proc_reset || do_flush)
                lru <= '0;
            else if (do_fill)
                lru[fill_idx] <= ~miss_way;
            else if (do_hit)
                lru[req_idx] <= ~hit_way;
        end
    end else begin : g_one
        assign hit_way    = 1'b0;
        assign victim_way = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (proc_reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state     = state;
        bus.proc_stall = 1'b0;
        bus.proc_rdata = '0;
        do_hit         = 1'b0;
        do_miss        = 1'b0;
        do_fill        = 1'b0;
        do_flush       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.proc_flush) begin
                    do_flush       = 1'b1;
                    bus.proc_stall = bus.proc_read;
                end else if (bus.proc_read) begin
                    if (hit) begin
                        do_hit         = 1'b1;
                        bus.proc_rdata = hit_line[req_off*DATA_W +: DATA_W];
                    end else begin
                        do_miss        = 1'b1;
                        bus.proc_stall = 1'b1;
                        next_state     = FETCH;
                    end
                end
            end
            FETCH: begin
                bus.proc_stall = 1'b1;
                if (bus.L2_ready) begin
                    do_fill    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset || do_flush)
            valid <= '{default: '0};
        else if (do_fill)
            valid[fill_idx][miss_way] <= 1'b1;
    end

    // Line payload and the pending-miss bookkeeping need no reset: valid gates their use.
    always_ff @(posedge clk) begin
        if (do_fill) begin
            data_mem[fill_idx][miss_way] <= bus.L2_rdata;
            tag_mem[fill_idx][miss_way]  <= fill_tag;
        end
        if (do_miss) begin
            miss_line <= bus.proc_addr[ADDR_W-1:OFF_W];
            miss_way  <= victim_way;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (do_hit && hit_cnt != '1)
                hit_cnt <= hit_cnt + 1'b1;
            if (do_miss && miss_cnt != '1)
                miss_cnt <= miss_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_icache_l1_assoc.sv
// Directed bench for icache_l1_assoc: a 2-way instance and a direct-mapped instance
// with 2-bit counters share one stimulus; sel picks the instance being observed.
module tb_icache_l1_assoc;
    logic         clk;
    logic         proc_reset;
    logic         proc_read;
    logic         proc_flush;
    logic [29:0]  proc_addr;
    logic         l2_ready;
    logic [127:0] l2_rdata;
    logic         sel;
    int           vectors = 0;
    int           miscompares = 0;

    logic [15:0] sa_hit, sa_miss;
    logic [1:0]  dm_hit, dm_miss;

    icache_l1_assoc_if sa_bus ();
    icache_l1_assoc_if dm_bus ();

    assign sa_bus.proc_read  = proc_read;
    assign sa_bus.proc_addr  = proc_addr;
    assign sa_bus.proc_flush = proc_flush;
    assign sa_bus.L2_rdata   = l2_rdata;
    assign sa_bus.L2_ready   = l2_ready;
    assign dm_bus.proc_read  = proc_read;
    assign dm_bus.proc_addr  = proc_addr;
    assign dm_bus.proc_flush = proc_flush;
    assign dm_bus.L2_rdata   = l2_rdata;
    assign dm_bus.L2_ready   = l2_ready;

    icache_l1_assoc #(.WAYS(2)) dut_sa (
        .clk(clk), .proc_reset(proc_reset), .bus(sa_bus),
        .hit_cnt(sa_hit), .miss_cnt(sa_miss)
    );

    icache_l1_assoc #(.WAYS(1), .CNT_W(2)) dut_dm (
        .clk(clk), .proc_reset(proc_reset), .bus(dm_bus),
        .hit_cnt(dm_hit), .miss_cnt(dm_miss)
    );

    wire        obs_stall   = sel ? dm_bus.proc_stall : sa_bus.proc_stall;
    wire [31:0] obs_rdata   = sel ? dm_bus.proc_rdata : sa_bus.proc_rdata;
    wire        obs_l2_read = sel ? dm_bus.L2_read    : sa_bus.L2_read;
    wire [27:0] obs_l2_addr = sel ? dm_bus.L2_addr    : sa_bus.L2_addr;
    wire [15:0] obs_hit     = sel ? {14'd0, dm_hit}   : sa_hit;
    wire [15:0] obs_miss    = sel ? {14'd0, dm_miss}  : sa_miss;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word k of a line is ((line ^ 1) << 8) | k*0x11, so line 1 holds 0x00,0x11,0x22,0x33.
    function automatic logic [127:0] lineData(input logic [27:0] line);
        logic [127:0] d;
        for (int k = 0; k < 4; k++)
            d[32*k +: 32] = (({4'd0, line} ^ 32'd1) << 8) | 32'(k * 17);
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic [29:0] addr, input logic fl);
        proc_read  = rd;
        proc_addr  = addr;
        proc_flush = fl;
        #1;
    endtask

    task automatic resetDut();
        proc_reset = 1'b1;
        l2_ready   = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        tick();
        proc_reset = 1'b0;
        #1;
    endtask

    // L2 model: answers after L2_read has been high for 'latency' cycles; returns stall cycles seen.
    task automatic runMiss(input int latency, output int stalls);
        int seen = 0;
        stalls = 0;
        while (obs_stall && stalls < 40) begin
            stalls++;
            tick();
            l2_ready = 1'b0;
            if (obs_l2_read) begin
                if (seen == latency) begin
                    l2_ready = 1'b1;
                    l2_rdata = lineData(obs_l2_addr);
                end
                seen++;
            end
            #1;
        end
        l2_ready = 1'b0;
    endtask

    task automatic readMiss(input string tag, input logic [29:0] addr, input logic [31:0] exp);
        int stalls;
        applyStimulus(1'b1, addr, 1'b0);
        checkOutput({tag, "_stall"}, 32'(obs_stall), 32'd1);
        runMiss(3, stalls);
        checkOutput({tag, "_cycles"}, stalls, 32'd5);
        checkOutput({tag, "_data"}, obs_rdata, exp);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
    endtask

    task automatic readHit(input string tag, input logic [29:0] addr, input logic [31:0] exp);
        applyStimulus(1'b1, addr, 1'b0);
        checkOutput({tag, "_stall"}, 32'(obs_stall), 32'd0);
        checkOutput({tag, "_l2read"}, 32'(obs_l2_read), 32'd0);
        checkOutput({tag, "_data"}, obs_rdata, exp);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
    endtask

    initial begin
        sel      = 1'b0;
        l2_rdata = '0;
        resetDut();
        checkOutput("rst_stall", 32'(obs_stall), 32'd0);
        checkOutput("rst_rdata", obs_rdata, 32'd0);
        checkOutput("rst_l2read", 32'(obs_l2_read), 32'd0);
        checkOutput("rst_hit", obs_hit, 32'd0);
        checkOutput("rst_miss", obs_miss, 32'd0);

        readMiss("cold", 30'h5, 32'h11);
        checkOutput("cold_miss_cnt", obs_miss, 32'd1);
        checkOutput("cold_hit_cnt", obs_hit, 32'd1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 30'(4 + k), 1'b0);
            checkOutput($sformatf("line_stall%0d", k), 32'(obs_stall), 32'd0);
            checkOutput($sformatf("line_data%0d", k), obs_rdata, 32'(k * 17));
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("line_hit_cnt", obs_hit, 32'd5);
        checkOutput("line_miss_cnt", obs_miss, 32'd1);

        resetDut();
        readMiss("lru_a", 30'h05, 32'h11);
        readMiss("lru_b", 30'h25, 32'h811);
        readHit("lru_a_hit", 30'h05, 32'h11);
        readMiss("lru_c", 30'h45, 32'h1011);
        readHit("lru_a_kept", 30'h05, 32'h11);
        readHit("lru_c_hit", 30'h46, 32'h1022);
        readMiss("lru_b_gone", 30'h25, 32'h811);

        sel = 1'b1;
        resetDut();
        readMiss("dm_a", 30'h05, 32'h11);
        readMiss("dm_b", 30'h25, 32'h811);
        readMiss("dm_a_again", 30'h05, 32'h11);
        checkOutput("dm_miss_cnt", obs_miss, 32'd3);
        checkOutput("dm_hit_cnt", obs_hit, 32'd3);
        readMiss("dm_b_again", 30'h25, 32'h811);
        checkOutput("dm_miss_sat", obs_miss, 32'd3);
        checkOutput("dm_hit_sat", obs_hit, 32'd3);
        sel = 1'b0;

        resetDut();
        readMiss("fl_a", 30'h05, 32'h11);
        readMiss("fl_b", 30'h08, 32'h300);
        applyStimulus(1'b1, 30'h05, 1'b1);
        checkOutput("fl_stall", 32'(obs_stall), 32'd1);
        checkOutput("fl_l2read", 32'(obs_l2_read), 32'd0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("fl_l2read_after", 32'(obs_l2_read), 32'd0);
        checkOutput("fl_miss_cnt", obs_miss, 32'd2);
        checkOutput("fl_hit_cnt", obs_hit, 32'd2);
        readMiss("fl_a_refetch", 30'h05, 32'h11);
        readMiss("fl_b_refetch", 30'h08, 32'h300);

        resetDut();
        applyStimulus(1'b1, 30'h05, 1'b0);
        tick();
        checkOutput("rf_l2read", 32'(obs_l2_read), 32'd1);
        tick();
        proc_reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        proc_reset = 1'b0;
        #1;
        checkOutput("rf_l2read_rst", 32'(obs_l2_read), 32'd0);
        checkOutput("rf_stall_rst", 32'(obs_stall), 32'd0);
        checkOutput("rf_hit_rst", obs_hit, 32'd0);
        checkOutput("rf_miss_rst", obs_miss, 32'd0);
        l2_ready = 1'b1;
        l2_rdata = {4{32'hDEADBEEF}};
        tick();
        l2_ready = 1'b0;
        #1;
        checkOutput("rf_late_ready", 32'(obs_l2_read), 32'd0);
        readMiss("rf_remiss", 30'h05, 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
